// File: rtl/alu_divider_if.sv
// Operand/result handshake bundle shared by the execute stage and the divider.
// master drives operands and result back-pressure; slave is the divider.
interface alu_divider_if #(
   parameter int unsigned XLEN = 32
) ();
   logic            in_valid;
   logic            in_ready;
   logic [XLEN-1:0] operand1;
   logic [XLEN-1:0] operand2;
   logic [2:0]      func3;
   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] result;

   modport master (
      output in_valid, operand1, operand2, func3, out_ready,
      input  in_ready, out_valid, result
   );

   modport slave (
      input  in_valid, operand1, operand2, func3, out_ready,
      output in_ready, out_valid, result
   );
endinterface

// File: rtl/alu_divider.sv
// Iterative restoring divider for DIV/DIVU/REM/REMU, one quotient bit per cycle.
// Special cases (divide by zero, signed overflow, unsupported func3) finish in one cycle.
module alu_divider #(
   parameter int unsigned XLEN = 32
) (
   input  logic         clk,
   input  logic         rst,
   alu_divider_if.slave bus
);
   localparam int unsigned CntW = $clog2(XLEN);
   localparam logic [XLEN-1:0] MinInt = {1'b1, {(XLEN-1){1'b0}}};

   typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

   state_e          state_q, state_d;
   logic [CntW-1:0] count_q, count_d;
   logic [XLEN:0]   rem_q, rem_d;
   logic [XLEN-1:0] quo_q, quo_d;
   logic [XLEN-1:0] dvsr_q, dvsr_d;
   logic [XLEN-1:0] result_q, result_d;
   logic            neg_quo_q, neg_quo_d;
   logic            neg_rem_q, neg_rem_d;
   logic            is_rem_q, is_rem_d;

   logic            is_signed, op1_neg, op2_neg;
   logic            unsupported, div_zero, overflow;
   logic [XLEN-1:0] op1_abs, op2_abs, special_res;
   logic [XLEN:0]   shifted, diff, rem_nxt;
   logic [XLEN-1:0] quo_nxt, quo_fix, rem_fix;
   logic            unused_rem_msb;

   // The remainder never exceeds the divisor, so its top bit is always clear.
   assign unused_rem_msb = rem_q[XLEN];

   always_comb begin
      is_signed   = ~bus.func3[0];
      op1_neg     = is_signed & bus.operand1[XLEN-1];
      op2_neg     = is_signed & bus.operand2[XLEN-1];
      op1_abs     = op1_neg ? -bus.operand1 : bus.operand1;
      op2_abs     = op2_neg ? -bus.operand2 : bus.operand2;
      unsupported = ~bus.func3[2];
      div_zero    = (bus.operand2 == '0);
      overflow    = is_signed && (bus.operand1 == MinInt) && (bus.operand2 == '1);

      special_res = '0;
      if (unsupported) begin
         special_res = '0;
      end else if (div_zero) begin
         special_res = bus.func3[1] ? bus.operand1 : '1;
      end else if (overflow) begin
         special_res = bus.func3[1] ? '0 : MinInt;
      end
   end

   // One restoring step: shift in the next dividend bit, subtract if it fits.
   always_comb begin
      shifted = {rem_q[XLEN-1:0], quo_q[XLEN-1]};
      diff    = shifted - {1'b0, dvsr_q};
      rem_nxt = diff[XLEN] ? shifted : diff;
      quo_nxt = {quo_q[XLEN-2:0], ~diff[XLEN]};
      quo_fix = neg_quo_q ? -quo_nxt : quo_nxt;
      rem_fix = neg_rem_q ? -rem_nxt[XLEN-1:0] : rem_nxt[XLEN-1:0];
   end

   always_comb begin
      state_d   = state_q;
      count_d   = count_q;
      rem_d     = rem_q;
      quo_d     = quo_q;
      dvsr_d    = dvsr_q;
      result_d  = result_q;
      neg_quo_d = neg_quo_q;
      neg_rem_d = neg_rem_q;
      is_rem_d  = is_rem_q;

      case (state_q)
         StIdle: begin
            if (bus.in_valid) begin
               if (unsupported || div_zero || overflow) begin
                  result_d = special_res;
                  state_d  = StDone;
               end else begin
                  count_d   = '0;
                  rem_d     = '0;
                  quo_d     = op1_abs;
                  dvsr_d    = op2_abs;
                  neg_quo_d = op1_neg ^ op2_neg;
                  neg_rem_d = op1_neg;
                  is_rem_d  = bus.func3[1];
                  state_d   = StBusy;
               end
            end
         end
         StBusy: begin
            rem_d   = rem_nxt;
            quo_d   = quo_nxt;
            count_d = count_q + 1'b1;
            // Last step folds in the sign fix so DONE follows the XLEN-th cycle.
            if (count_q == CntW'(XLEN - 1)) begin
               result_d = is_rem_q ? rem_fix : quo_fix;
               state_d  = StDone;
            end
         end
         StDone: begin
            if (bus.out_ready) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= StIdle;
         count_q   <= '0;
         rem_q     <= '0;
         quo_q     <= '0;
         dvsr_q    <= '0;
         result_q  <= '0;
         neg_quo_q <= 1'b0;
         neg_rem_q <= 1'b0;
         is_rem_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         count_q   <= count_d;
         rem_q     <= rem_d;
         quo_q     <= quo_d;
         dvsr_q    <= dvsr_d;
         result_q  <= result_d;
         neg_quo_q <= neg_quo_d;
         neg_rem_q <= neg_rem_d;
         is_rem_q  <= is_rem_d;
      end
   end

   assign bus.in_ready  = (state_q == StIdle);
   assign bus.out_valid = (state_q == StDone);
   assign bus.result    = result_q;
endmodule

// File: tb/tb_alu_divider.sv
// Scoreboard bench for alu_divider: directed ops push expected result and latency,
// an independent monitor checks each result as out_valid rises.
module tb_alu_divider;
   localparam int unsigned XLEN = 32;

   typedef struct {
      logic [XLEN-1:0] res;
      int              acc;
      int              lat;
      string           name;
   } exp_t;

   logic clk;
   logic rst;
   int   cyc    = 0;
   int   checks = 0;
   int   errors = 0;
   exp_t sb[$];
   exp_t mon_e;
   logic mon_prev = 1'b0;

   alu_divider_if #(.XLEN(XLEN)) bus ();

   alu_divider #(.XLEN(XLEN)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic check(input string name, input logic [XLEN-1:0] act,
                        input logic [XLEN-1:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: actual=0x%08h required=0x%08h", name, act, req);
      end
   endtask

   // Latency counts the cycle right after the accept edge as cycle 1.
   initial forever begin
      @(negedge clk);
      if (bus.out_valid === 1'b1 && !mon_prev) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_out_valid: actual result=0x%08h required no output",
                     bus.result);
         end else begin
            mon_e = sb.pop_front();
            check({mon_e.name, "_result"}, bus.result, mon_e.res);
            check({mon_e.name, "_latency"}, 32'(cyc - mon_e.acc + 1), 32'(mon_e.lat));
         end
      end
      mon_prev = (bus.out_valid === 1'b1);
   end

   task automatic issue(input string name, input logic [2:0] f, input logic [XLEN-1:0] a,
                        input logic [XLEN-1:0] b, input logic [XLEN-1:0] res,
                        input int lat, input bit expect_out);
      exp_t e;
      int   g = 0;
      @(negedge clk);
      while (bus.in_ready !== 1'b1 && g < 200) begin
         @(negedge clk);
         g++;
      end
      check({name, "_in_ready"}, 32'(bus.in_ready), 32'd1);
      bus.in_valid = 1'b1;
      bus.func3    = f;
      bus.operand1 = a;
      bus.operand2 = b;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      if (expect_out) begin
         e.res  = res;
         e.acc  = cyc;
         e.lat  = lat;
         e.name = name;
         sb.push_back(e);
      end
   endtask

   task automatic drain();
      int g = 0;
      while ((sb.size() != 0 || bus.in_ready !== 1'b1) && g < 300) begin
         @(negedge clk);
         g++;
      end
      check("drain_queue_empty", 32'(sb.size()), 32'd0);
   endtask

   initial begin
      int g;
      bit seen;
      rst          = 1'b1;
      bus.in_valid = 1'b0;
      bus.operand1 = '0;
      bus.operand2 = '0;
      bus.func3    = 3'b000;
      bus.out_ready = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      check("reset_in_ready", 32'(bus.in_ready), 32'd1);
      check("reset_out_valid", 32'(bus.out_valid), 32'd0);
      check("reset_result", bus.result, 32'h0);

      issue("div_32_m6", 3'b100, 32'd32, 32'hFFFF_FFFA, 32'hFFFF_FFFB, 33, 1'b1);
      issue("rem_32_m6", 3'b110, 32'd32, 32'hFFFF_FFFA, 32'd2, 33, 1'b1);
      issue("divu_max_2", 3'b101, 32'hFFFF_FFFF, 32'd2, 32'h7FFF_FFFF, 33, 1'b1);
      issue("remu_max_2", 3'b111, 32'hFFFF_FFFF, 32'd2, 32'd1, 33, 1'b1);
      issue("div_14_0", 3'b100, 32'd14, 32'd0, 32'hFFFF_FFFF, 1, 1'b1);
      issue("remu_14_0", 3'b111, 32'd14, 32'd0, 32'd14, 1, 1'b1);
      issue("divu_5_0", 3'b101, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, 1'b1);
      issue("rem_14_0", 3'b110, 32'd14, 32'd0, 32'd14, 1, 1'b1);
      issue("div_ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 1'b1);
      issue("rem_ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1, 1'b1);
      issue("divu_min_m1", 3'b101, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 33, 1'b1);
      issue("remu_min_m1", 3'b111, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 33, 1'b1);
      issue("div_m7_2", 3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33, 1'b1);
      issue("rem_m7_2", 3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33, 1'b1);
      issue("div_m20_m3", 3'b100, 32'hFFFF_FFEC, 32'hFFFF_FFFD, 32'd6, 33, 1'b1);
      issue("rem_m20_m3", 3'b110, 32'hFFFF_FFEC, 32'hFFFF_FFFD, 32'hFFFF_FFFE, 33, 1'b1);
      issue("div_min_2", 3'b100, 32'h8000_0000, 32'd2, 32'hC000_0000, 33, 1'b1);
      issue("divu_0_5", 3'b101, 32'd0, 32'd5, 32'd0, 33, 1'b1);
      issue("unsup_000", 3'b000, 32'd99, 32'd3, 32'd0, 1, 1'b1);
      issue("unsup_011", 3'b011, 32'd99, 32'd0, 32'd0, 1, 1'b1);
      drain();

      // Backpressure: result must hold and new requests must be ignored.
      bus.out_ready = 1'b0;
      issue("bp_divu", 3'b101, 32'd1000, 32'd10, 32'd100, 33, 1'b1);
      g = 0;
      while (bus.out_valid !== 1'b1 && g < 100) begin
         @(negedge clk);
         g++;
      end
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("bp_result_hold", bus.result, 32'd100);
         check("bp_in_ready_low", 32'(bus.in_ready), 32'd0);
         check("bp_out_valid_high", 32'(bus.out_valid), 32'd1);
         bus.in_valid = (i == 1);
         bus.func3    = 3'b100;
         bus.operand1 = 32'd14;
         bus.operand2 = 32'd0;
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      @(negedge clk);
      check("bp_release_in_ready", 32'(bus.in_ready), 32'd1);
      check("bp_release_out_valid", 32'(bus.out_valid), 32'd0);
      check("bp_idle_result_hold", bus.result, 32'd100);
      repeat (3) @(negedge clk);
      drain();

      // Reset on BUSY cycle 10 aborts the operation.
      issue("abort_divu", 3'b101, 32'd500, 32'd3, 32'd0, 0, 1'b0);
      repeat (10) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("abort_in_ready", 32'(bus.in_ready), 32'd1);
      check("abort_out_valid", 32'(bus.out_valid), 32'd0);
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (bus.out_valid === 1'b1) seen = 1'b1;
      end
      check("abort_no_out_valid", 32'(seen), 32'd0);

      issue("divu_100_7", 3'b101, 32'd100, 32'd7, 32'd14, 33, 1'b1);
      drain();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
